// File: rtl/load_axi_read_master.sv
// AXI4 read master: splits a byte-length transfer into 4 KB-safe bursts, caps ARs in flight,
// and streams the returned beats through a 2-entry skid FIFO with a transfer-level tlast.
module load_axi_read_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_MAX_BURST        = 16,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst,
    input  logic                          read_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
    output logic                          read_done,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          data_tvalid,
    input  logic                          data_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
    output logic                          data_tlast
);
    localparam int BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int LOG2_BEAT  = $clog2(BEAT_BYTES);
    localparam int PAGE_BEATS = 4096 / BEAT_BYTES;
    localparam int SZ_W       = C_XFER_SIZE_WIDTH + 1;
    localparam int BEAT_W     = SZ_W - LOG2_BEAT;
    localparam int LEN_W      = 13;
    localparam int OUT_W      = $clog2(C_MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [BEAT_W-1:0]             r_ar_left;
    logic [BEAT_W-1:0]             r_out_left;
    logic [OUT_W-1:0]              r_outstanding;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_fifo_mem [2];
    logic                          r_fifo_wr;
    logic                          r_fifo_rd;
    logic [1:0]                    r_fifo_count;

    logic [BEAT_W-1:0] w_total_beats;
    logic [LEN_W-1:0]  w_to_page;
    logic [LEN_W-1:0]  w_left_cap;
    logic [LEN_W-1:0]  w_burst_len;
    logic              w_start;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_r_last_hs;
    logic              w_pop;

    // Extra top bit keeps the round-up from overflowing on the largest sizes.
    assign w_total_beats = BEAT_W'((SZ_W'(dram_xfer_size_in_bytes) + SZ_W'(BEAT_BYTES - 1)) >> LOG2_BEAT);

    assign w_to_page   = LEN_W'(PAGE_BEATS) - LEN_W'(r_araddr[11:LOG2_BEAT]);
    assign w_left_cap  = (r_ar_left > BEAT_W'(C_MAX_BURST)) ? LEN_W'(C_MAX_BURST) : LEN_W'(r_ar_left);
    assign w_burst_len = (w_left_cap < w_to_page) ? w_left_cap : w_to_page;

    assign w_start     = (r_state == S_IDLE) && read_start;
    assign w_ar_hs     = m_axi_arvalid && m_axi_arready;
    assign w_r_hs      = m_axi_rvalid && m_axi_rready;
    assign w_r_last_hs = w_r_hs && m_axi_rlast;
    assign w_pop       = data_tvalid && data_tready;

    // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (read_start) w_next_state = S_RUN;
            S_RUN:   if ((r_out_left == '0) || (w_pop && (r_out_left == BEAT_W'(1))))
                         w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // arvalid is derived from registers that only move on a handshake, so it is stable under stall.
    always_comb begin
        read_done     = (r_state == S_DONE);
        m_axi_arvalid = (r_state == S_RUN) && (r_ar_left != '0) &&
                        (r_outstanding != OUT_W'(C_MAX_OUTSTANDING));
        m_axi_arlen   = m_axi_arvalid ? 8'(w_burst_len - LEN_W'(1)) : 8'd0;
        m_axi_araddr  = r_araddr;
        m_axi_rready  = (r_state == S_RUN) && (r_fifo_count != 2'd2);
        data_tvalid   = (r_fifo_count != 2'd0);
        data_tdata    = r_fifo_mem[r_fifo_rd];
        data_tlast    = data_tvalid && (r_out_left == BEAT_W'(1));
    end

    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            r_araddr      <= '0;
            r_ar_left     <= '0;
            r_out_left    <= '0;
            r_outstanding <= '0;
        end else if (w_start) begin
            r_araddr      <= dram_xfer_start_addr;
            r_ar_left     <= w_total_beats;
            r_out_left    <= w_total_beats;
            r_outstanding <= '0;
        end else begin
            if (w_ar_hs) begin
                r_araddr  <= r_araddr + (C_M_AXI_ADDR_WIDTH'(w_burst_len) << LOG2_BEAT);
                r_ar_left <= r_ar_left - BEAT_W'(w_burst_len);
            end
            case ({w_ar_hs, w_r_last_hs})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_pop) begin
                r_out_left <= r_out_left - BEAT_W'(1);
            end
        end
    end

    // NOTE: the FIFO storage is reset too, because data_tdata must read zero out of reset.
    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_mem[i] <= '0;
            end
            r_fifo_wr    <= 1'b0;
            r_fifo_rd    <= 1'b0;
            r_fifo_count <= 2'd0;
        end else begin
            if (w_r_hs) begin
                r_fifo_mem[r_fifo_wr] <= m_axi_rdata;
                r_fifo_wr             <= ~r_fifo_wr;
            end
            if (w_pop) begin
                r_fifo_rd <= ~r_fifo_rd;
            end
            case ({w_r_hs, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
                2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_load_axi_read_master.sv
// Directed bench for load_axi_read_master: behavioural AXI read slave, stream sink and
// per-scenario tasks with hand-computed burst lists and beat patterns.
module tb_load_axi_read_master;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = 32;

    logic          kernel_clk = 1'b0;
    logic          kernel_rst;
    logic          read_start;
    logic [AW-1:0] dram_xfer_start_addr;
    logic [SW-1:0] dram_xfer_size_in_bytes;
    logic          read_done;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axi_rdata;
    logic          m_axi_rlast;
    logic          data_tvalid;
    logic          data_tready;
    logic [DW-1:0] data_tdata;
    logic          data_tlast;

    always #5 kernel_clk = ~kernel_clk;

    load_axi_read_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_XFER_SIZE_WIDTH (SW),
        .C_MAX_BURST       (16),
        .C_MAX_OUTSTANDING (4)
    ) dut (
        .kernel_clk             (kernel_clk),
        .kernel_rst             (kernel_rst),
        .read_start             (read_start),
        .dram_xfer_start_addr   (dram_xfer_start_addr),
        .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
        .read_done              (read_done),
        .m_axi_arvalid          (m_axi_arvalid),
        .m_axi_arready          (m_axi_arready),
        .m_axi_araddr           (m_axi_araddr),
        .m_axi_arlen            (m_axi_arlen),
        .m_axi_rvalid           (m_axi_rvalid),
        .m_axi_rready           (m_axi_rready),
        .m_axi_rdata            (m_axi_rdata),
        .m_axi_rlast            (m_axi_rlast),
        .data_tvalid            (data_tvalid),
        .data_tready            (data_tready),
        .data_tdata             (data_tdata),
        .data_tlast             (data_tlast)
    );

    int checks   = 0;
    int failures = 0;

    bit arready_en, arready_rand, rvalid_en, tready_en, tready_rand;

    logic [AW-1:0] ar_addr_q [$];
    int            ar_len_q  [$];
    logic [AW-1:0] pend_addr [$];
    int            pend_len  [$];
    int            beat_idx;
    logic [DW-1:0] out_data  [$];
    logic          out_last  [$];
    int            done_count, occ, saw_full, rready_full_viol, hold_viol, outst, max_outst;

    logic          p_arvalid, p_arready, p_tvalid, p_tready, p_rst;
    logic [AW-1:0] p_araddr;
    logic [7:0]    p_arlen;
    logic [DW-1:0] p_tdata;

    function automatic logic [DW-1:0] beat_pattern(input logic [AW-1:0] a);
        return {(DW/AW){a}};
    endfunction

    // Slave + sink + monitor: sample handshakes at the edge, drive new inputs 1 time unit later.
    always begin
        @(posedge kernel_clk);
        if (p_arvalid && !p_arready && !p_rst &&
            (!m_axi_arvalid || m_axi_araddr !== p_araddr || m_axi_arlen !== p_arlen))
            hold_viol++;
        if (p_tvalid && !p_tready && !p_rst && (!data_tvalid || data_tdata !== p_tdata))
            hold_viol++;
        if (occ == 2) begin
            saw_full++;
            if (m_axi_rready) rready_full_viol++;
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_addr_q.push_back(m_axi_araddr);
            ar_len_q.push_back(int'(m_axi_arlen));
            pend_addr.push_back(m_axi_araddr);
            pend_len.push_back(int'(m_axi_arlen) + 1);
            outst++;
        end
        if (m_axi_rvalid && m_axi_rready) begin
            occ++;
            beat_idx++;
            if (pend_len.size() > 0 && beat_idx == pend_len[0]) begin
                void'(pend_addr.pop_front());
                void'(pend_len.pop_front());
                beat_idx = 0;
                outst--;
            end
        end
        if (data_tvalid && data_tready) begin
            out_data.push_back(data_tdata);
            out_last.push_back(data_tlast);
            occ--;
        end
        if (outst > max_outst) max_outst = outst;
        if (read_done) done_count++;
        if (kernel_rst) occ = 0;
        p_arvalid = m_axi_arvalid; p_arready = m_axi_arready; p_araddr = m_axi_araddr;
        p_arlen   = m_axi_arlen;   p_tvalid  = data_tvalid;   p_tready = data_tready;
        p_tdata   = data_tdata;    p_rst     = kernel_rst;
        #1;
        m_axi_arready = arready_rand ? 1'($urandom_range(0, 1)) : arready_en;
        data_tready   = tready_rand  ? 1'($urandom_range(0, 1)) : tready_en;
        if (rvalid_en && pend_len.size() > 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beat_pattern(pend_addr[0] + AW'(beat_idx * 64));
            m_axi_rlast  = (beat_idx == pend_len[0] - 1);
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rlast  = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge kernel_clk);
        #2;
    endtask

    task automatic clear_model();
        ar_addr_q.delete(); ar_len_q.delete(); pend_addr.delete(); pend_len.delete();
        out_data.delete();  out_last.delete();
        beat_idx = 0; done_count = 0; occ = 0; saw_full = 0; rready_full_viol = 0;
        hold_viol = 0; outst = 0; max_outst = 0;
    endtask

    task automatic start_xfer(input logic [AW-1:0] addr, input int size);
        read_start              = 1'b1;
        dram_xfer_start_addr    = addr;
        dram_xfer_size_in_bytes = SW'(size);
        tick(1);
        read_start              = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (done_count == 0 && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (done_count == 0) begin
            failures++;
            $display("FAIL %s_timeout: no read_done within %0d cycles, required one pulse", name, limit);
        end
        tick(3);
    endtask

    function automatic int stream_errors(input logic [AW-1:0] base, input int nbeats);
        int n = 0;
        if (out_data.size() != nbeats) return 1000 + out_data.size();
        for (int k = 0; k < nbeats; k++) begin
            if (out_data[k] !== beat_pattern(base + AW'(k * 64))) n++;
            if (out_last[k] !== (k == nbeats - 1)) n++;
        end
        return n;
    endfunction

    function automatic int page_cross_count();
        int n = 0;
        for (int i = 0; i < ar_addr_q.size(); i++)
            if (int'(ar_addr_q[i][11:0]) + (ar_len_q[i] + 1) * 64 > 4096) n++;
        return n;
    endfunction

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({read_done, m_axi_arvalid, m_axi_rready, data_tvalid, data_tlast} !== 5'b0) begin
            failures++;
            $display("FAIL %s_ctrl: done/arvalid/rready/tvalid/tlast=%b, required 00000", name,
                     {read_done, m_axi_arvalid, m_axi_rready, data_tvalid, data_tlast});
        end
        checks++;
        if (m_axi_araddr !== '0 || m_axi_arlen !== 8'd0 || data_tdata !== '0) begin
            failures++;
            $display("FAIL %s_data: araddr=%h arlen=%0d tdata_lsw=%h, required all zero", name,
                     m_axi_araddr, m_axi_arlen, data_tdata[63:0]);
        end
    endtask

    task automatic test_reset();
        kernel_rst = 1'b1;
        read_start = 1'b1;
        dram_xfer_start_addr    = 64'h40;
        dram_xfer_size_in_bytes = 32'd256;
        tick(2);
        @(negedge kernel_clk);
        check_reset_outputs("reset");
        clear_model();
        read_start = 1'b0;
        kernel_rst = 1'b0;
        tick(6);
        checks++;
        if (ar_addr_q.size() != 0 || done_count != 0 || m_axi_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored: ARs=%0d dones=%0d arvalid=%b, required 0 0 0",
                     ar_addr_q.size(), done_count, m_axi_arvalid);
        end
    endtask

    task automatic test_basic();
        int e;
        clear_model();
        arready_en = 1; rvalid_en = 1; tready_en = 1;
        start_xfer(64'h0, 128);
        wait_done("basic", 100);
        checks++;
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 64'h0 || ar_len_q[0] != 1) begin
            failures++;
            $display("FAIL basic_ar: %0d ARs, first addr=%h len=%0d, required 1 AR at 0 len 1",
                     ar_addr_q.size(), ar_addr_q.size() ? ar_addr_q[0] : 64'h0,
                     ar_len_q.size() ? ar_len_q[0] : -1);
        end
        e = stream_errors(64'h0, 2);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL basic_stream: %0d errors over %0d beats, required 0 over 2", e, out_data.size());
        end
        checks++;
        if (done_count != 1) begin
            failures++;
            $display("FAIL basic_done: %0d read_done pulses, required 1", done_count);
        end
    endtask

    task automatic test_long_burst();
        int e;
        clear_model();
        start_xfer(64'h0, 1024);
        wait_done("burst16", 200);
        checks++;
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 64'h0 || ar_len_q[0] != 15) begin
            failures++;
            $display("FAIL burst16_ar: %0d ARs, first len=%0d, required 1 AR at 0 len 15",
                     ar_addr_q.size(), ar_len_q.size() ? ar_len_q[0] : -1);
        end
        e = stream_errors(64'h0, 16);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL burst16_stream: %0d errors over %0d beats, required 0 over 16", e, out_data.size());
        end
    endtask

    task automatic test_4k_boundary();
        int e;
        clear_model();
        start_xfer(64'hF80, 256);
        wait_done("page", 200);
        checks++;
        if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 64'hF80 || ar_len_q[0] != 1 ||
            ar_addr_q[1] !== 64'h1000 || ar_len_q[1] != 1) begin
            failures++;
            $display("FAIL page_ar: %0d ARs, required (F80,1) then (1000,1)", ar_addr_q.size());
        end
        checks++;
        if (page_cross_count() != 0) begin
            failures++;
            $display("FAIL page_cross: %0d bursts cross 4KB, required 0", page_cross_count());
        end
        e = stream_errors(64'hF80, 4);
        checks++;
        if (e != 0 || done_count != 1) begin
            failures++;
            $display("FAIL page_stream: %0d errors, %0d dones, required 0 errors and 1 done", e, done_count);
        end
    endtask

    task automatic test_odd_and_zero();
        int e;
        clear_model();
        start_xfer(64'h3000, 100);
        wait_done("odd", 100);
        e = stream_errors(64'h3000, 2);
        checks++;
        if (e != 0 || ar_len_q.size() != 1 || ar_len_q[0] != 1) begin
            failures++;
            $display("FAIL odd_size: %0d errors, %0d ARs, required 2 beats from 1 AR len 1", e, ar_len_q.size());
        end
        clear_model();
        start_xfer(64'h5000, 0);
        checks++;
        if (read_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_early: read_done=%b one cycle after start, required 0", read_done);
        end
        tick(1);
        checks++;
        if (read_done !== 1'b1) begin
            failures++;
            $display("FAIL zero_done: read_done=%b two cycles after start, required 1", read_done);
        end
        tick(1);
        checks++;
        if (read_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse: read_done=%b three cycles after start, required 0", read_done);
        end
        tick(3);
        checks++;
        if (ar_addr_q.size() != 0 || done_count != 1) begin
            failures++;
            $display("FAIL zero_ar: %0d ARs, %0d dones, required 0 ARs and 1 done", ar_addr_q.size(), done_count);
        end
    endtask

    task automatic test_outstanding();
        int e, bad;
        clear_model();
        rvalid_en = 0;
        start_xfer(64'h0, 8192);
        tick(20);
        checks++;
        if (ar_addr_q.size() != 4 || m_axi_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL outst_stall: %0d ARs with arvalid=%b, required 4 ARs and arvalid 0",
                     ar_addr_q.size(), m_axi_arvalid);
        end
        rvalid_en = 1;
        wait_done("outst", 1000);
        bad = 0;
        for (int i = 0; i < ar_addr_q.size(); i++)
            if (ar_addr_q[i] !== AW'(i * 1024) || ar_len_q[i] != 15) bad++;
        checks++;
        if (ar_addr_q.size() != 8 || bad != 0) begin
            failures++;
            $display("FAIL outst_ar: %0d ARs with %0d wrong, required 8 ARs of len 15 at k*0x400",
                     ar_addr_q.size(), bad);
        end
        checks++;
        if (max_outst != 4) begin
            failures++;
            $display("FAIL outst_max: peak %0d ARs in flight, required 4", max_outst);
        end
        e = stream_errors(64'h0, 128);
        checks++;
        if (e != 0 || done_count != 1) begin
            failures++;
            $display("FAIL outst_stream: %0d errors, %0d dones, required 0 and 1", e, done_count);
        end
    endtask

    task automatic test_backpressure();
        int e;
        clear_model();
        arready_rand = 1; tready_rand = 1;
        start_xfer(64'hE00, 2048);
        wait_done("bp", 2000);
        arready_rand = 0; tready_rand = 0;
        checks++;
        if (ar_addr_q.size() != 3 || ar_addr_q[0] !== 64'hE00 || ar_len_q[0] != 7 ||
            ar_addr_q[1] !== 64'h1000 || ar_len_q[1] != 15 ||
            ar_addr_q[2] !== 64'h1400 || ar_len_q[2] != 7) begin
            failures++;
            $display("FAIL bp_ar: %0d ARs, required (E00,7) (1000,15) (1400,7)", ar_addr_q.size());
        end
        e = stream_errors(64'hE00, 32);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL bp_stream: %0d errors over %0d beats, required 0 over 32", e, out_data.size());
        end
        checks++;
        if (saw_full == 0 || rready_full_viol != 0) begin
            failures++;
            $display("FAIL bp_rready: full cycles=%0d rready-while-full=%0d, required >0 and 0",
                     saw_full, rready_full_viol);
        end
        checks++;
        if (hold_viol != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d AR/stream stability violations under stall, required 0", hold_viol);
        end
    endtask

    task automatic test_reset_mid();
        int rr, e;
        clear_model();
        tready_en = 0;
        start_xfer(64'h0, 1024);
        tick(6);
        checks++;
        if (data_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_setup: tvalid=%b before reset, required 1", data_tvalid);
        end
        kernel_rst = 1'b1;
        tick(1);
        kernel_rst = 1'b0;
        check_reset_outputs("midrst");
        rr = 0;
        repeat (5) begin
            if (m_axi_rready !== 1'b0) rr++;
            tick(1);
        end
        checks++;
        if (rr != 0 || done_count != 0) begin
            failures++;
            $display("FAIL midrst_stale: rready high %0d cycles, %0d dones, required 0 and 0", rr, done_count);
        end
        tready_en = 1;
        clear_model();
        start_xfer(64'h2000, 256);
        wait_done("midrst_next", 200);
        e = stream_errors(64'h2000, 4);
        checks++;
        if (e != 0 || done_count != 1 || ar_addr_q.size() != 1 || ar_len_q[0] != 3) begin
            failures++;
            $display("FAIL midrst_next: %0d errors, %0d dones, %0d ARs, required 0, 1, 1 AR len 3",
                     e, done_count, ar_addr_q.size());
        end
    endtask

    initial begin
        kernel_rst = 1'b1;
        read_start = 1'b0;
        dram_xfer_start_addr    = '0;
        dram_xfer_size_in_bytes = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rlast   = 1'b0;
        data_tready   = 1'b0;
        arready_en = 0; arready_rand = 0; rvalid_en = 0; tready_en = 0; tready_rand = 0;
        clear_model();
        test_reset();
        test_basic();
        test_long_burst();
        test_4k_boundary();
        test_odd_and_zero();
        test_outstanding();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
